bank_sram_ctrl: RTL

- Bank SRAM controller. Sits directly downstream of the bank issue queue and consumes its iq_sc_* issue stream, one request at a time.
- Executes four operations against the bank data SRAM: write from the write buffer, read, read with linefill, and write-back.
- Returns read data and write acknowledges to the requesting crossbar channel, and pushes dirty write-back beats to the BIU.

---
 rtl/bank_sram_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/bank_sram_ctrl.sv
// Bank SRAM controller: executes one issue-queue request at a time against the
// bank data SRAM (buffered write, read, read with linefill, dirty write-back),
// returns responses to the crossbar channel and pushes write-back beats to the BIU.
`timescale 1ns/1ps
module bank_sram_ctrl #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  iq_sc_valid_i,
  output logic                  iq_sc_ready_o,
  input  logic [1:0]            iq_sc_channel_id_i,
  input  logic [2:0]            iq_sc_opcode_i,
  input  logic [6:0]            iq_sc_set_way_offset_i,
  input  logic [7:0]            iq_sc_wbuffer_id_i,
  input  logic [2:0]            iq_sc_xbar_rob_num_i,
  input  logic [1:0]            iq_sc_cacheline_state_offset0_i,
  input  logic [1:0]            iq_sc_cacheline_state_offset1_i,
  output logic                  sc_wbuf_ren_o,
  output logic [7:0]            sc_wbuf_rid_o,
  input  logic [DATA_WIDTH-1:0] wbuf_sc_rdata_i,
  output logic                  sc_lfb_ren_o,
  output logic [7:0]            sc_lfb_rid_o,
  input  logic [DATA_WIDTH-1:0] lfb_sc_rdata_i,
  output logic                  sram_cen_o,
  output logic                  sram_wen_o,
  output logic [6:0]            sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic [2:0]            sc_ch_valid_o,
  input  logic [2:0]            sc_ch_ready_i,
  output logic [2:0]            sc_ch_rob_num_o,
  output logic                  sc_ch_is_write_o,
  output logic [DATA_WIDTH-1:0] sc_ch_rdata_o,
  output logic                  sc_biu_wvalid_o,
  input  logic                  biu_sc_wready_i,
  output logic [6:0]            sc_biu_waddr_o,
  output logic [DATA_WIDTH-1:0] sc_biu_wdata_o
);

  typedef enum logic [2:0] {
    IDLE, BUF_RD, SRAM_WR, SRAM_RD, CAP, CH_RSP, WB_CHK, BIU_SEND
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_FILL  = 2'd2;
  localparam logic [1:0] OP_WB    = 2'd3;
  localparam logic [1:0] NO_CHAN  = 2'd3;

  state_t                  state_reg;
  logic [1:0]              op_reg;
  logic [1:0]              ch_reg;
  logic [6:0]              addr_reg;
  logic [2:0]              rob_reg;
  logic [1:0]              mask_reg;
  logic                    idx_reg;
  logic [DATA_WIDTH-1:0]   data_reg;

  logic                    wb_sel;
  logic                    rsp_fire;
  logic                    unused_opcode_msb;

  // Opcode bit 2 is reserved; it is deliberately dropped.
  assign unused_opcode_msb = iq_sc_opcode_i[2];

  // Lowest dirty offset first: pick offset 1 only when offset 0 is clean.
  assign wb_sel   = ~mask_reg[0];
  assign rsp_fire = |(sc_ch_valid_o & sc_ch_ready_i);

  assign iq_sc_ready_o = (state_reg == IDLE);

  // Buffer data arrives the cycle after the read enable, i.e. during SRAM_WR.
  assign sram_wdata_o = (state_reg != SRAM_WR) ? '0 :
                        (op_reg == OP_FILL) ? lfb_sc_rdata_i : wbuf_sc_rdata_i;

  // Response / beat data is zero whenever it is not being presented.
  assign sc_ch_rdata_o  = (state_reg == CH_RSP && !sc_ch_is_write_o) ? data_reg : '0;
  assign sc_biu_wdata_o = (state_reg == BIU_SEND) ? data_reg : '0;

  // Request sequencing FSM with registered strobes and handshake outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg        <= IDLE;
      op_reg           <= '0;
      ch_reg           <= '0;
      addr_reg         <= '0;
      rob_reg          <= '0;
      mask_reg         <= '0;
      idx_reg          <= 1'b0;
      data_reg         <= '0;
      sc_wbuf_ren_o    <= 1'b0;
      sc_wbuf_rid_o    <= '0;
      sc_lfb_ren_o     <= 1'b0;
      sc_lfb_rid_o     <= '0;
      sram_cen_o       <= 1'b0;
      sram_wen_o       <= 1'b0;
      sram_addr_o      <= '0;
      sc_ch_valid_o    <= '0;
      sc_ch_rob_num_o  <= '0;
      sc_ch_is_write_o <= 1'b0;
      sc_biu_wvalid_o  <= 1'b0;
      sc_biu_waddr_o   <= '0;
    end else begin
      // Single-cycle strobes default low.
      sc_wbuf_ren_o <= 1'b0;
      sc_lfb_ren_o  <= 1'b0;
      sram_cen_o    <= 1'b0;
      sram_wen_o    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (iq_sc_valid_i) begin
            op_reg   <= iq_sc_opcode_i[1:0];
            ch_reg   <= iq_sc_channel_id_i;
            addr_reg <= iq_sc_set_way_offset_i;
            rob_reg  <= iq_sc_xbar_rob_num_i;
            mask_reg <= {iq_sc_cacheline_state_offset1_i == 2'b11,
                         iq_sc_cacheline_state_offset0_i == 2'b11};
            unique case (iq_sc_opcode_i[1:0])
              OP_WRITE: begin
                sc_wbuf_ren_o <= 1'b1;
                sc_wbuf_rid_o <= iq_sc_wbuffer_id_i;
                state_reg     <= BUF_RD;
              end
              OP_FILL: begin
                sc_lfb_ren_o <= 1'b1;
                sc_lfb_rid_o <= iq_sc_wbuffer_id_i;
                state_reg    <= BUF_RD;
              end
              OP_READ: begin
                sram_cen_o  <= 1'b1;
                sram_addr_o <= iq_sc_set_way_offset_i;
                state_reg   <= SRAM_RD;
              end
              OP_WB: state_reg <= WB_CHK;
            endcase
          end
        end
        BUF_RD: begin
          sram_cen_o  <= 1'b1;
          sram_wen_o  <= 1'b1;
          sram_addr_o <= addr_reg;
          state_reg   <= SRAM_WR;
        end
        SRAM_WR: begin
          if (op_reg == OP_FILL) data_reg <= lfb_sc_rdata_i;
          if (ch_reg == NO_CHAN) begin
            state_reg <= IDLE;
          end else begin
            sc_ch_valid_o    <= 3'b001 << ch_reg;
            sc_ch_rob_num_o  <= rob_reg;
            sc_ch_is_write_o <= (op_reg == OP_WRITE);
            state_reg        <= CH_RSP;
          end
        end
        SRAM_RD: state_reg <= CAP;
        CAP: begin
          data_reg <= sram_rdata_i;
          if (op_reg == OP_WB) begin
            sc_biu_wvalid_o <= 1'b1;
            sc_biu_waddr_o  <= {addr_reg[6:1], idx_reg};
            state_reg       <= BIU_SEND;
          end else if (ch_reg == NO_CHAN) begin
            state_reg <= IDLE;
          end else begin
            sc_ch_valid_o    <= 3'b001 << ch_reg;
            sc_ch_rob_num_o  <= rob_reg;
            sc_ch_is_write_o <= 1'b0;
            state_reg        <= CH_RSP;
          end
        end
        CH_RSP: begin
          if (rsp_fire) begin
            sc_ch_valid_o    <= '0;
            sc_ch_rob_num_o  <= '0;
            sc_ch_is_write_o <= 1'b0;
            state_reg        <= IDLE;
          end
        end
        WB_CHK: begin
          if (mask_reg == 2'b00) begin
            state_reg <= IDLE;
          end else begin
            idx_reg     <= wb_sel;
            sram_cen_o  <= 1'b1;
            sram_addr_o <= {addr_reg[6:1], wb_sel};
            state_reg   <= SRAM_RD;
          end
        end
        BIU_SEND: begin
          if (biu_sc_wready_i) begin
            sc_biu_wvalid_o   <= 1'b0;
            sc_biu_waddr_o    <= '0;
            mask_reg[idx_reg] <= 1'b0;
            state_reg         <= WB_CHK;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
